// File: rtl/note_envelope_controller.sv
// note_envelope_controller
//   Monophonic keyboard envelope generator. The lowest-index pressed key is
//   the sounding key. Volume ramps up by ATTACK_STEP on each envelope tick,
//   holds at full scale while the key is held, then ramps down by
//   RELEASE_STEP on each tick after the last key is released. A key change
//   while sounding retunes the note without touching the envelope (legato).
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   keys[6:0]  : key levels, already synchronized (bit0=A .. bit6=J), 1=pressed
//   note[3:0]  : index of the current or last sounding key, 0..6
//   volume[7:0]: envelope amplitude, 0..255
//   key_active : one-hot bit of the sounding key, zero when no key is held
//   busy       : high whenever the envelope is not idle
module note_envelope_controller #(
  parameter int TICK_DIV     = 50000,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] keys,
  output logic [3:0] note,
  output logic [7:0] volume,
  output logic [6:0] key_active,
  output logic       busy
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    winner;
  logic          any_key;
  logic [3:0]    note_nxt;
  logic [7:0]    volume_nxt;
  logic [6:0]    key_active_nxt;

  // Attack ramp, saturating at full scale.
  function automatic logic [7:0] sat_add(input logic [7:0] v);
    logic signed [9:0] s;
    s = $signed({2'b00, v}) + $signed(10'(ATTACK_STEP));
    sat_add = (s > 10'sd255) ? 8'd255 : s[7:0];
  endfunction

  // Release ramp, saturating at silence.
  function automatic logic [7:0] sat_sub(input logic [7:0] v);
    logic signed [9:0] s;
    s = $signed({2'b00, v}) - $signed(10'(RELEASE_STEP));
    sat_sub = (s < 10'sd0) ? 8'd0 : s[7:0];
  endfunction

  // Free-running envelope time base; never resynchronized by key activity.
  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  // Lowest-index pressed key wins; scan from the top so bit 0 overrides.
  always_comb begin
    winner = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (keys[i]) winner = 4'(i);
    end
  end

  assign any_key = |keys;

  always_comb begin
    state_nxt      = state;
    note_nxt       = note;
    volume_nxt     = volume;
    key_active_nxt = key_active;
    case (state)
      IDLE: begin
        volume_nxt     = 8'd0;
        key_active_nxt = 7'd0;
        if (any_key) begin
          note_nxt       = winner;
          key_active_nxt = 7'd1 << winner[2:0];
          state_nxt      = ATTACK;
        end
      end
      ATTACK, SUSTAIN: begin
        if (state == SUSTAIN) volume_nxt = 8'd255;
        if (!any_key) begin
          // Release wins over a coincident tick.
          key_active_nxt = 7'd0;
          state_nxt      = RELEASE;
        end else if (winner != note) begin
          // Legato retune: envelope untouched on this edge.
          note_nxt       = winner;
          key_active_nxt = 7'd1 << winner[2:0];
        end else if (state == ATTACK && tick) begin
          volume_nxt = sat_add(volume);
          if (volume_nxt == 8'd255) state_nxt = SUSTAIN;
        end
      end
      RELEASE: begin
        key_active_nxt = 7'd0;
        if (any_key) begin
          // Re-attack from the current level; the press wins over a tick.
          note_nxt       = winner;
          key_active_nxt = 7'd1 << winner[2:0];
          state_nxt      = ATTACK;
        end else if (tick) begin
          volume_nxt = sat_sub(volume);
          if (volume_nxt == 8'd0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      note       <= 4'd0;
      volume     <= 8'd0;
      key_active <= 7'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      note       <= note_nxt;
      volume     <= volume_nxt;
      key_active <= key_active_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_note_envelope_controller.sv
// Directed bench for note_envelope_controller with TICK_DIV=4 and both steps
// at 64. The tick counter restarts at reset, so envelope ticks land on every
// fourth edge after the reset edge; expected values below are laid out along
// that schedule (edge numbers counted from the last reset edge).
module tb_note_envelope_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] keys;
  logic [3:0] note;
  logic [7:0] volume;
  logic [6:0] key_active;
  logic       busy;

  int total = 0;
  int bad   = 0;

  note_envelope_controller #(
    .TICK_DIV    (4),
    .ATTACK_STEP (64),
    .RELEASE_STEP(64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keys      (keys),
    .note      (note),
    .volume    (volume),
    .key_active(key_active),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    keys = 7'd0;
    step(2);                              // E0 = last reset edge, counter 0
    chk("rst_note", note, 0);
    chk("rst_vol", volume, 0);
    chk("rst_ka", key_active, 0);
    chk("rst_busy", busy, 0);

    // Attack ramp from idle on key A.
    rst  = 1'b0;
    keys = 7'b0000001;
    step(1);                              // E1
    chk("atk_note", note, 0);
    chk("atk_ka", key_active, 7'b0000001);
    chk("atk_busy", busy, 1);
    chk("atk_vol0", volume, 0);
    step(2);                              // E3
    chk("atk_pre_tick", volume, 0);
    step(1);                              // E4 tick
    chk("atk_vol64", volume, 64);
    step(4);                              // E8
    chk("atk_vol128", volume, 128);
    step(4);                              // E12
    chk("atk_vol192", volume, 192);
    step(4);                              // E16
    chk("atk_vol255", volume, 255);
    step(1);                              // E17
    chk("sus_vol", volume, 255);
    chk("sus_busy", busy, 1);

    // Release ramp back to idle.
    keys = 7'd0;
    step(1);                              // E18
    chk("rel_ka", key_active, 0);
    chk("rel_vol_hold", volume, 255);
    chk("rel_busy", busy, 1);
    step(2);                              // E20
    chk("rel_vol191", volume, 191);
    step(4);                              // E24
    chk("rel_vol127", volume, 127);
    step(4);                              // E28
    chk("rel_vol63", volume, 63);
    step(4);                              // E32
    chk("rel_vol0", volume, 0);
    chk("idle_busy", busy, 0);
    chk("idle_note", note, 0);

    // Multiple keys: lowest wins; then legato retune in sustain.
    keys = 7'b1010000;
    step(1);                              // E33
    chk("multi_note", note, 4);
    chk("multi_ka", key_active, 7'b0010000);
    step(15);                             // E48
    chk("multi_vol255", volume, 255);
    keys = 7'b1000000;
    step(1);                              // E49
    chk("leg_note", note, 6);
    chk("leg_ka", key_active, 7'b1000000);
    chk("leg_vol", volume, 255);
    chk("leg_busy", busy, 1);
    step(3);                              // E52 tick
    chk("leg_sus_vol", volume, 255);

    // Re-attack from release at 127, press coincident with a tick.
    keys = 7'd0;
    step(4);                              // E56
    chk("rel2_vol191", volume, 191);
    step(4);                              // E60
    chk("rel2_vol127", volume, 127);
    step(3);                              // E63
    keys = 7'b0000100;
    step(1);                              // E64 tick
    chk("reatk_note", note, 2);
    chk("reatk_ka", key_active, 7'b0000100);
    chk("reatk_vol", volume, 127);
    step(4);                              // E68
    chk("reatk_vol191", volume, 191);

    // Release coincident with an attack tick: no volume change.
    step(3);                              // E71
    keys = 7'd0;
    step(1);                              // E72 tick
    chk("reltick_vol", volume, 191);
    chk("reltick_ka", key_active, 0);
    chk("reltick_busy", busy, 1);
    step(4);                              // E76
    chk("reltick_vol127", volume, 127);
    step(8);                              // E84
    chk("rel3_vol0", volume, 0);
    chk("rel3_busy", busy, 0);

    // Reset mid-attack at 128, key held through reset.
    keys = 7'b0000010;
    step(1);                              // E85
    chk("atk3_note", note, 1);
    step(7);                              // E92
    chk("atk3_vol128", volume, 128);
    rst = 1'b1;
    step(1);                              // new E0
    chk("mid_rst_note", note, 0);
    chk("mid_rst_vol", volume, 0);
    chk("mid_rst_ka", key_active, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    step(1);                              // E1
    chk("post_rst_note", note, 1);
    chk("post_rst_ka", key_active, 7'b0000010);
    chk("post_rst_busy", busy, 1);
    step(2);                              // E3
    chk("post_rst_pre_tick", volume, 0);
    step(1);                              // E4 tick
    chk("post_rst_vol64", volume, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
